fancytimer_tx: RTL and testbench
================================

FANCYTIMER_TX -- requirements
Module: fancytimer_tx

Interface
REQ-001 Parameter GAP_CYCLES, default 2: number of zero bits driven on data before the preamble; 0 means no gap.
REQ-002 Parameter TMO_MARGIN, default 16: extra cycles allowed beyond the nominal timer duration before timeout.
REQ-003 clk  input  1  clock; all state changes on the rising edge.
REQ-004 reset  input  1  reset, synchronous, active-high.
REQ-005 start  input  1  command request; sampled only in IDLE.
REQ-006 delay  input  4  timer delay code; captured with start.
REQ-007 data  output  1  serial command stream to the timer.
REQ-008 done  input  1  timer-finished indication from the timer.
REQ-009 ack  output  1  acknowledge to the timer.
REQ-010 busy  output  1  high in every state except IDLE.
REQ-011 complete  output  1  one-cycle pulse on successful handshake.
REQ-012 elapsed  output  15  WAIT_DONE cycle count; valid when complete=1, held until the next start.
REQ-013 timeout  output  1  one-cycle pulse on watchdog abort; constant 0 when the watchdog is compiled out.

Function
REQ-014 FSM states: IDLE, GAP, PRE, DLY, WAIT_DONE, ACK; all outputs are registered (Moore) from state and counters.
REQ-015 IDLE: data=0, ack=0; start=1 captures delay, clears elapsed, and moves to GAP (GAP_CYCLES>0) or to PRE.
REQ-016 GAP: data=0 for exactly GAP_CYCLES cycles, then PRE.
REQ-017 PRE: data drives 1,1,0,1 on 4 consecutive cycles, then DLY.
REQ-018 DLY: data drives delay[3],delay[2],delay[1],delay[0] (MSB first) on 4 cycles, then WAIT_DONE.
REQ-019 WAIT_DONE: data=0; the elapsed counter increments each cycle, saturating at 15'h7FFF; done=1 moves to ACK.
REQ-020 ACK: ack=1 for exactly one cycle; complete pulses on the same cycle; next state IDLE.
REQ-021 The start-to-first-preamble-bit latency is GAP_CYCLES+1 cycles; there is no back-to-back issue, and IDLE lasts at least 1 cycle between commands.
REQ-022 start while busy=1 is ignored; done outside WAIT_DONE is ignored.
REQ-023 A delay change after capture has no effect on the command in flight.

Reset
REQ-024 On reset: state=IDLE; data, ack, busy, complete, and timeout are 0; elapsed=0; captured delay=0.
REQ-025 Reset in any state, including mid-stream, aborts the command on the next edge with no ack or complete pulse.

Configuration
REQ-026 Macro FANCYTIMER_TX_WATCHDOG_EN: when defined, WAIT_DONE with elapsed reaching (delay+1)*1000+TMO_MARGIN and done=0 goes to IDLE, pulses timeout for 1 cycle, and gives no ack or complete.
REQ-027 With the watchdog compiled in, done=1 on the same cycle as the limit takes the ACK path and timeout stays 0.
REQ-028 Without the macro, WAIT_DONE waits for done indefinitely and timeout is tied 0.

Structure
REQ-029 Shared package fancytimer_pkg holds the state enum, PREAMBLE=4'b1101, CYCLES_PER_UNIT=1000, and ELAPSED_W=15.
REQ-030 The bit serialiser (8-bit load-and-shift register plus 3-bit bit counter, MSB first) is sub-module fancytimer_ser.
REQ-031 The FSM, elapsed counter, and watchdog stay in fancytimer_tx.

Verification
REQ-032 Scenario 1: start with delay=4'h0 and defaults -> data 0,0,1,1,0,1,0,0,0,0, then 0; done after 1000 WAIT cycles -> ack and complete for 1 cycle, elapsed=1000.
REQ-033 Scenario 2: delay=4'hA -> DLY bits 1,0,1,0; a bench receiver model counts 11000 cycles and raises done -> one ack, busy falls the cycle after ack.
REQ-034 Scenario 3: start pulsed during PRE and during WAIT_DONE -> no effect; done pulsed in IDLE -> no ack.
REQ-035 Scenario 4: reset asserted on the second DLY bit -> next cycle data=0, busy=0, no complete; a fresh start works normally.
REQ-036 Scenario 5 (FANCYTIMER_TX_WATCHDOG_EN): delay=0, done never raised -> timeout pulse when elapsed=1016, state IDLE, ack never 1.
REQ-037 Scenario 6: GAP_CYCLES=0, delay=4'hF -> first data bit 1 on the cycle after start; done on the watchdog limit cycle -> ack, timeout=0.

Source files
------------

// File: rtl/fancytimer_pkg.sv
// Shared types and constants for the fancytimer command transmitter.
package fancytimer_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_GAP,
    ST_PRE,
    ST_DLY,
    ST_WAIT_DONE,
    ST_ACK
  } state_e;

  localparam logic [3:0] PREAMBLE        = 4'b1101;
  localparam int         CYCLES_PER_UNIT = 1000;
  localparam int         ELAPSED_W       = 15;
  // Two extra bits so the limit compare can never wrap.
  localparam int         LIMIT_W         = ELAPSED_W + 2;

  // Watchdog threshold: nominal timer duration plus the allowed margin.
  function automatic logic [LIMIT_W-1:0] tmo_limit(input logic [3:0] dly, input int margin);
    int lim;
    lim = (int'(dly) + 1) * CYCLES_PER_UNIT + margin;
    return LIMIT_W'(lim);
  endfunction

endpackage

// File: rtl/fancytimer_ser.sv
// MSB-first load-and-shift serialiser with a 3-bit bit counter.
// The register is zero whenever it is not streaming, so sdo doubles as the idle-low line.
module fancytimer_ser (
  input  logic       clk,
  input  logic       reset,
  input  logic       load,
  input  logic [7:0] load_data,
  input  logic       shift,
  output logic       sdo,
  output logic [2:0] bit_cnt
);

  logic [7:0] shreg_q, shreg_d;
  logic [2:0] cnt_q, cnt_d;

  // Load a fresh word, or shift one bit out and count it.
  always_comb begin
    shreg_d = shreg_q;
    cnt_d   = cnt_q;
    if (load) begin
      shreg_d = load_data;
      cnt_d   = 3'd0;
    end else if (shift) begin
      shreg_d = {shreg_q[6:0], 1'b0};
      cnt_d   = cnt_q + 3'd1;
    end
  end

  // Shift register and counter state.
  always_ff @(posedge clk) begin
    if (reset) begin
      shreg_q <= 8'h00;
      cnt_q   <= 3'd0;
    end else begin
      shreg_q <= shreg_d;
      cnt_q   <= cnt_d;
    end
  end

  assign sdo     = shreg_q[7];
  assign bit_cnt = cnt_q;

endmodule

// File: rtl/fancytimer_tx.sv
// Timer command transmitter: gap, preamble and delay code out serially, then waits
// for done and acknowledges. Optional watchdog enabled by FANCYTIMER_TX_WATCHDOG_EN.
module fancytimer_tx
  import fancytimer_pkg::*;
#(
  parameter int GAP_CYCLES = 2,
  parameter int TMO_MARGIN = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [3:0]           delay,
  output logic                 data,
  input  logic                 done,
  output logic                 ack,
  output logic                 busy,
  output logic                 complete,
  output logic [ELAPSED_W-1:0] elapsed,
  output logic                 timeout
);

  localparam logic [15:0]          GAP_LAST    = 16'(GAP_CYCLES - 1);
  localparam logic [ELAPSED_W-1:0] ELAPSED_MAX = '1;

  state_e               state_q, state_d;
  logic [15:0]          gap_cnt_q, gap_cnt_d;
  logic [3:0]           delay_q, delay_d;
  logic [ELAPSED_W-1:0] elapsed_q, elapsed_d;
  logic                 ack_q, ack_d;
  logic                 complete_q, complete_d;
  logic                 busy_q, busy_d;
  logic                 ser_load, ser_shift;
  logic [7:0]           ser_word;
  logic [2:0]           ser_cnt;

`ifdef FANCYTIMER_TX_WATCHDOG_EN
  logic               timeout_q, timeout_d;
  logic [LIMIT_W-1:0] wd_limit;
  assign wd_limit = tmo_limit(delay_q, TMO_MARGIN);
`endif

  // When loading straight out of IDLE the captured delay is not yet registered.
  assign ser_word  = {PREAMBLE, (state_q == ST_IDLE) ? delay : delay_q};
  assign ser_shift = (state_q == ST_PRE) || (state_q == ST_DLY);

  fancytimer_ser u_ser (
    .clk       (clk),
    .reset     (reset),
    .load      (ser_load),
    .load_data (ser_word),
    .shift     (ser_shift),
    .sdo       (data),
    .bit_cnt   (ser_cnt)
  );

  // Next-state, counters and registered output values.
  always_comb begin
    state_d   = state_q;
    gap_cnt_d = gap_cnt_q;
    delay_d   = delay_q;
    elapsed_d = elapsed_q;
    ser_load  = 1'b0;
`ifdef FANCYTIMER_TX_WATCHDOG_EN
    timeout_d = 1'b0;
`endif
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          delay_d   = delay;
          elapsed_d = '0;
          gap_cnt_d = 16'd0;
          if (GAP_CYCLES > 0) begin
            state_d = ST_GAP;
          end else begin
            state_d  = ST_PRE;
            ser_load = 1'b1;
          end
        end
      end
      ST_GAP: begin
        if (gap_cnt_q == GAP_LAST) begin
          state_d  = ST_PRE;
          ser_load = 1'b1;
        end else begin
          gap_cnt_d = gap_cnt_q + 16'd1;
        end
      end
      ST_PRE: begin
        if (ser_cnt == 3'd3) state_d = ST_DLY;
      end
      ST_DLY: begin
        if (ser_cnt == 3'd7) state_d = ST_WAIT_DONE;
      end
      ST_WAIT_DONE: begin
        elapsed_d = (elapsed_q == ELAPSED_MAX) ? elapsed_q : elapsed_q + 1'b1;
        if (done) begin
          state_d = ST_ACK;
        end
`ifdef FANCYTIMER_TX_WATCHDOG_EN
        else if ({2'b00, elapsed_d} >= wd_limit) begin
          state_d   = ST_IDLE;
          timeout_d = 1'b1;
        end
`endif
      end
      ST_ACK: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    ack_d      = (state_d == ST_ACK);
    complete_d = (state_d == ST_ACK);
    busy_d     = (state_d != ST_IDLE);
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      gap_cnt_q  <= 16'd0;
      delay_q    <= 4'h0;
      elapsed_q  <= '0;
      ack_q      <= 1'b0;
      complete_q <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      gap_cnt_q  <= gap_cnt_d;
      delay_q    <= delay_d;
      elapsed_q  <= elapsed_d;
      ack_q      <= ack_d;
      complete_q <= complete_d;
      busy_q     <= busy_d;
    end
  end

`ifdef FANCYTIMER_TX_WATCHDOG_EN
  // Watchdog abort pulse.
  always_ff @(posedge clk) begin
    if (reset) timeout_q <= 1'b0;
    else       timeout_q <= timeout_d;
  end
  assign timeout = timeout_q;
`else
  assign timeout = 1'b0;
`endif

  assign ack      = ack_q;
  assign complete = complete_q;
  assign busy     = busy_q;
  assign elapsed  = elapsed_q;

endmodule

// File: tb/tb_fancytimer_tx.sv
// Directed testbench for fancytimer_tx; outputs sampled on the falling edge.
module tb_fancytimer_tx;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0, start2 = 1'b0;
  logic [3:0]  delay = 4'h0, delay2 = 4'h0;
  logic        done = 1'b0, done2 = 1'b0;
  logic        data, ack, busy, complete, timeout;
  logic        data2, ack2, busy2, complete2, timeout2;
  logic [14:0] elapsed, elapsed2;

  int checks = 0;
  int passes = 0;

  always #5 clk = ~clk;

  fancytimer_tx dut (
    .clk(clk), .reset(reset), .start(start), .delay(delay), .data(data),
    .done(done), .ack(ack), .busy(busy), .complete(complete),
    .elapsed(elapsed), .timeout(timeout)
  );

  fancytimer_tx #(.GAP_CYCLES(0)) dut0 (
    .clk(clk), .reset(reset), .start(start2), .delay(delay2), .data(data2),
    .done(done2), .ack(ack2), .busy(busy2), .complete(complete2),
    .elapsed(elapsed2), .timeout(timeout2)
  );

  // Pulse start for one cycle; returns at the falling edge of the first cycle after start.
  task automatic issue(input logic [3:0] d);
    @(negedge clk); start = 1'b1; delay = d;
    @(negedge clk); start = 1'b0;
  endtask

  // Record n consecutive data bits, oldest in the highest position.
  task automatic capture(input int n, output logic [15:0] bits);
    bits = '0;
    for (int i = 0; i < n; i++) begin
      if (i > 0) @(negedge clk);
      bits = {bits[14:0], data};
    end
  endtask

  // Called on the first WAIT_DONE cycle: raise done during the n-th WAIT_DONE cycle,
  // return on the ACK cycle, flagging any ack/complete seen before it.
  task automatic run_wait(input int n, output logic saw_early);
    saw_early = 1'b0;
    repeat (n - 1) begin
      @(negedge clk);
      if (ack !== 1'b0 || complete !== 1'b0) saw_early = 1'b1;
    end
    done = 1'b1;
    @(negedge clk);
    done = 1'b0;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    repeat (3) @(negedge clk);
    checks++; if ({data, ack, busy, complete, timeout} !== 5'b0) $display("FAIL reset_outs got=%b want=00000", {data, ack, busy, complete, timeout}); else passes++;
    checks++; if (elapsed !== 15'd0) $display("FAIL reset_elapsed got=%0d want=0", elapsed); else passes++;
    checks++; if ({data2, ack2, busy2, complete2, timeout2} !== 5'b0) $display("FAIL reset_outs_gap0 got=%b want=00000", {data2, ack2, busy2, complete2, timeout2}); else passes++;
    reset = 1'b0;
    @(negedge clk);
    checks++; if (busy !== 1'b0) $display("FAIL idle_busy got=%b want=0", busy); else passes++;
  endtask

  task automatic test_basic;
    logic [15:0] bits;
    logic        early;
    issue(4'h0);
    checks++; if (busy !== 1'b1) $display("FAIL s1_busy got=%b want=1", busy); else passes++;
    capture(11, bits);
    checks++; if (bits[10:0] !== 11'b00110100000) $display("FAIL s1_stream got=%b want=00110100000", bits[10:0]); else passes++;
    run_wait(1000, early);
    checks++; if (early !== 1'b0) $display("FAIL s1_early_ack got=%b want=0", early); else passes++;
    checks++; if ({ack, complete, busy} !== 3'b111) $display("FAIL s1_ack got=%b want=111", {ack, complete, busy}); else passes++;
    checks++; if (elapsed !== 15'd1000) $display("FAIL s1_elapsed got=%0d want=1000", elapsed); else passes++;
    @(negedge clk);
    checks++; if ({ack, complete, busy} !== 3'b000) $display("FAIL s1_after got=%b want=000", {ack, complete, busy}); else passes++;
    checks++; if (elapsed !== 15'd1000) $display("FAIL s1_hold got=%0d want=1000", elapsed); else passes++;
  endtask

  task automatic test_delay_a;
    logic [15:0] bits;
    logic        early;
    int          n;
    issue(4'hA);
    capture(11, bits);
    checks++; if (bits[10:0] !== 11'b00110110100) $display("FAIL s2_stream got=%b want=00110110100", bits[10:0]); else passes++;
    // Receiver model: decode the delay bits and wait (delay+1) units.
    n = (int'(bits[4:1]) + 1) * 1000;
    run_wait(n, early);
    checks++; if (early !== 1'b0) $display("FAIL s2_early_ack got=%b want=0", early); else passes++;
    checks++; if ({ack, busy} !== 2'b11) $display("FAIL s2_ack got=%b want=11", {ack, busy}); else passes++;
    checks++; if (elapsed !== 15'd11000) $display("FAIL s2_elapsed got=%0d want=11000", elapsed); else passes++;
    @(negedge clk);
    checks++; if ({ack, busy} !== 2'b00) $display("FAIL s2_busy_fall got=%b want=00", {ack, busy}); else passes++;
  endtask

  task automatic test_ignored;
    logic [15:0] bits;
    logic        early;
    @(negedge clk); start = 1'b1; delay = 4'h0;
    bits = '0;
    for (int c = 1; c <= 11; c++) begin
      @(negedge clk);
      start = (c == 3) || (c == 11);
      if (c >= 3) delay = 4'hF;
      bits = {bits[14:0], data};
    end
    @(negedge clk); start = 1'b0;
    checks++; if (bits[10:0] !== 11'b00110100000) $display("FAIL s3_stream got=%b want=00110100000", bits[10:0]); else passes++;
    run_wait(999, early);
    checks++; if ({early, ack, complete} !== 3'b011) $display("FAIL s3_ack got=%b want=011", {early, ack, complete}); else passes++;
    checks++; if (elapsed !== 15'd1000) $display("FAIL s3_elapsed got=%0d want=1000", elapsed); else passes++;
    @(negedge clk);
    done = 1'b1;
    @(negedge clk);
    done = 1'b0;
    checks++; if ({ack, complete, busy} !== 3'b000) $display("FAIL s3_idle_done got=%b want=000", {ack, complete, busy}); else passes++;
    @(negedge clk);
    checks++; if ({ack, complete, busy} !== 3'b000) $display("FAIL s3_idle_done2 got=%b want=000", {ack, complete, busy}); else passes++;
  endtask

  task automatic test_reset_midstream;
    logic [15:0] bits;
    logic        early;
    logic        seen;
    issue(4'hF);
    repeat (7) @(negedge clk);
    checks++; if (data !== 1'b1) $display("FAIL s4_dly_bit got=%b want=1", data); else passes++;
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    checks++; if ({data, busy, complete, ack} !== 4'b0000) $display("FAIL s4_abort got=%b want=0000", {data, busy, complete, ack}); else passes++;
    checks++; if (elapsed !== 15'd0) $display("FAIL s4_elapsed got=%0d want=0", elapsed); else passes++;
    seen = 1'b0;
    repeat (4) begin
      @(negedge clk);
      if (complete !== 1'b0 || ack !== 1'b0 || busy !== 1'b0) seen = 1'b1;
    end
    checks++; if (seen !== 1'b0) $display("FAIL s4_quiet got=%b want=0", seen); else passes++;
    issue(4'h3);
    capture(11, bits);
    checks++; if (bits[10:0] !== 11'b00110100110) $display("FAIL s4_restart got=%b want=00110100110", bits[10:0]); else passes++;
    run_wait(4000, early);
    checks++; if ({early, ack, complete} !== 3'b011) $display("FAIL s4_ack got=%b want=011", {early, ack, complete}); else passes++;
    checks++; if (elapsed !== 15'd4000) $display("FAIL s4_elapsed2 got=%0d want=4000", elapsed); else passes++;
    @(negedge clk);
  endtask

`ifdef FANCYTIMER_TX_WATCHDOG_EN
  task automatic test_watchdog;
    logic [15:0] bits;
    logic        seen;
    issue(4'h0);
    capture(11, bits);
    seen = 1'b0;
    repeat (1015) begin
      @(negedge clk);
      if (ack !== 1'b0 || timeout !== 1'b0 || busy !== 1'b1) seen = 1'b1;
    end
    @(negedge clk);
    checks++; if (seen !== 1'b0) $display("FAIL s5_early got=%b want=0", seen); else passes++;
    checks++; if ({timeout, ack, complete, busy} !== 4'b1000) $display("FAIL s5_timeout got=%b want=1000", {timeout, ack, complete, busy}); else passes++;
    checks++; if (elapsed !== 15'd1016) $display("FAIL s5_elapsed got=%0d want=1016", elapsed); else passes++;
    @(negedge clk);
    checks++; if ({timeout, ack} !== 2'b00) $display("FAIL s5_after got=%b want=00", {timeout, ack}); else passes++;
  endtask
`endif

  task automatic test_gap0_limit;
    logic [15:0] bits;
    logic        seen;
    @(negedge clk); start2 = 1'b1; delay2 = 4'hF;
    @(negedge clk); start2 = 1'b0;
    bits = '0;
    for (int i = 0; i < 9; i++) begin
      if (i > 0) @(negedge clk);
      bits = {bits[14:0], data2};
    end
    checks++; if (bits[8:0] !== 9'b110111110) $display("FAIL s6_stream got=%b want=110111110", bits[8:0]); else passes++;
    seen = 1'b0;
    repeat (16015) begin
      @(negedge clk);
      if (ack2 !== 1'b0 || timeout2 !== 1'b0) seen = 1'b1;
    end
    done2 = 1'b1;
    @(negedge clk);
    done2 = 1'b0;
    checks++; if (seen !== 1'b0) $display("FAIL s6_early got=%b want=0", seen); else passes++;
    checks++; if ({ack2, complete2, timeout2} !== 3'b110) $display("FAIL s6_ack got=%b want=110", {ack2, complete2, timeout2}); else passes++;
    checks++; if (elapsed2 !== 15'd16016) $display("FAIL s6_elapsed got=%0d want=16016", elapsed2); else passes++;
    @(negedge clk);
    checks++; if ({timeout2, busy2, ack2} !== 3'b000) $display("FAIL s6_after got=%b want=000", {timeout2, busy2, ack2}); else passes++;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_delay_a();
    test_ignored();
    test_reset_midstream();
`ifdef FANCYTIMER_TX_WATCHDOG_EN
    test_watchdog();
`endif
    test_gap0_limit();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
